trig_start_gen: RTL and testbench
=================================

// Module: trig_start_gen
// PURPOSE
//  Trigger detector on the sampling clock: produces the level Start consumed by the pre-sampling FIFO address counter.
//  Watches the ADC sample stream, arms only after pre-sampling is reported done (Sampled), then raises Start on a
//  qualified edge / pulse-width event. Start is held until ClrW, so the address counter's delay count runs while it is high.
// PARAMETERS
//  DW      8   sample width
//  TW      16  pulse-width counter / Tthr width
//  AUTO_W  20  auto-trigger timeout counter width (only with TRIG_AUTO_EN)
// PORTS
//  ClrW     in   1   reset, asynchronous, active-high
//  Wclk     in   1   sample clock, rising edge
//  Sampled  in   1   pre-sampling finished (from FIFO address counter)
//  Din      in   DW  current ADC sample, valid before each Wclk rise
//  Mode     in   3   trigger mode (see BEHAVIOUR)
//  Vthr     in   DW  trigger threshold
//  Hyst     in   DW  hysteresis band
//  Tthr     in   TW  pulse-width limit, in Wclk cycles
//  Force    in   1   force trigger, active-high
//  Start    out  1   trigger fired, level, held until ClrW
//  Armed    out  1   1 while in HUNT
//  Auto     out  1   Start caused by auto timeout
// BEHAVIOUR
//  Reset: state=WAIT_PRE, Start=0, Armed=0, Auto=0, Pcnt=0, level flags cleared. ClrW at any time, incl. FIRED, clears all immediately.
//  States: WAIT_PRE -> HUNT when Sampled=1; HUNT -> FIRED on fire condition; FIRED absorbing until ClrW.
//  Mode/Vthr/Hyst/Tthr latched on the WAIT_PRE->HUNT edge; later changes ignored until ClrW.
//  Lo = Vthr-Hyst saturated at 0; Hi = Vthr+Hyst saturated at 2^DW-1 (computed DW+1 bits wide, then clamped).
//  Level flag is level-tracking with hysteresis: set when Din>=Vthr, cleared when Din<Lo (positive modes);
//    set when Din<=Vthr, cleared when Din>Hi (negative modes). Flag is undefined/cleared on HUNT entry: first partial pulse ignored.
//  Modes: 0 rising: fire on edge where Din>=Vthr after a HUNT sample with Din<Lo.
//         1 falling: fire on edge where Din<=Vthr after a HUNT sample with Din>Hi.
//         2 +pulse <Tthr, 3 +pulse >=Tthr, 4 -pulse <Tthr, 5 -pulse >=Tthr: fire on the trailing-edge sample.
//         6 immediate: fire on first edge in HUNT.  7 never (Force/auto only).
//  Pcnt: cleared on pulse entry, +1 each edge the flag stays set, saturates at 2^TW-1; width = Pcnt at trailing edge.
//  Latency: qualifying Din presented before edge k -> state=FIRED, Start=1 after edge k (one register, no extra stage).
//  Force=1 in WAIT_PRE or HUNT -> FIRED on that edge; Force ignored in FIRED.
//  Simultaneous Force and fire condition -> FIRED once, Auto=0.
//  Sampled dropping after HUNT entry is ignored.
//  Armed = (state==HUNT), registered with the state.
// CONFIGURATION
//  TRIG_AUTO_EN defined: AUTO_W-bit counter cleared on HUNT entry, +1 per HUNT edge.
//    At all-ones with no fire -> FIRED with Start=1, Auto=1 on that edge.
//  TRIG_AUTO_EN undefined: counter absent; Auto tied 0; HUNT waits indefinitely.
// TESTING
//  Rising: Mode=0,Vthr=0x80,Hyst=4,Sampled=1; Din 0x70,0x80 -> Start=1 after 0x80 edge; Din 0x7E,0x80 only -> Start stays 0.
//  Arming: Sampled=0, edge 0x70->0x90 -> Start=0, Armed=0; Sampled=1, then 0x70,0x90 -> Armed=1, then Start=1.
//  Pulse: Mode=2,Tthr=10,Vthr=0x80; Din 0x10,0x90x5,0x10 -> Start on final 0x10 edge; 0x90x10 -> no Start; Mode=3, 0x90x10 -> Start.
//  Mode=7 + Force pulse -> Start=1 next edge, Auto=0; Mode=6 -> Start=1 one edge after HUNT entry.
//  ClrW pulse while Start=1 -> Start=0 asynchronously; back to WAIT_PRE, re-arms after Sampled.
//  TRIG_AUTO_EN, AUTO_W=4, Mode=7, Din constant -> Start=1 and Auto=1 after 16 HUNT edges.

Source files
------------

// File: rtl/trig_start_gen.sv
// trig_start_gen: trigger detector producing the Start level for the
// pre-sampling FIFO. Optional auto-trigger timeout: define TRIG_AUTO_EN.
module trig_start_gen #(
    parameter int DW = 8,
    parameter int TW = 16
`ifdef TRIG_AUTO_EN
    ,
    parameter int AUTO_W = 20
`endif
) (
    input  logic          ClrW,
    input  logic          Wclk,
    input  logic          Sampled,
    input  logic [DW-1:0] Din,
    input  logic [2:0]    Mode,
    input  logic [DW-1:0] Vthr,
    input  logic [DW-1:0] Hyst,
    input  logic [TW-1:0] Tthr,
    input  logic          Force,
    output logic          Start,
    output logic          Armed,
    output logic          Auto
);

    typedef enum logic [1:0] {
        WAIT_PRE = 2'd0,
        HUNT     = 2'd1,
        FIRED    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    mode_q, mode_d;
    logic [DW-1:0] vthr_q, vthr_d;
    logic [DW-1:0] hyst_q, hyst_d;
    logic [TW-1:0] tthr_q, tthr_d;
    logic          flag_q, flag_d;
    logic          known_q, known_d;
    logic [TW-1:0] pcnt_q, pcnt_d;
    logic          armed_q, armed_d;
    logic          start_q, start_d;
    logic          auto_q, auto_d;
    logic          auto_hit;

`ifdef TRIG_AUTO_EN
    logic [AUTO_W-1:0] acnt_q, acnt_d;
`endif

    logic [DW:0]   lo_w, hi_w;
    logic [DW-1:0] lo, hi;
    logic          neg, act, inact;
    logic          lead, trail;
    logic [TW-1:0] width;
    logic          fire;

    // Thresholds, level qualification and the per-mode fire condition.
    always_comb begin
        lo_w  = {1'b0, vthr_q} - {1'b0, hyst_q};
        hi_w  = {1'b0, vthr_q} + {1'b0, hyst_q};
        lo    = lo_w[DW] ? '0 : lo_w[DW-1:0];
        hi    = hi_w[DW] ? '1 : hi_w[DW-1:0];
        neg   = (mode_q == 3'd1) || (mode_q == 3'd4) || (mode_q == 3'd5);
        act   = neg ? (Din <= vthr_q) : (Din >= vthr_q);
        inact = neg ? (Din > hi) : (Din < lo);
        // Flag only becomes set once the inactive side has been seen,
        // so a pulse already in progress at arming is ignored.
        lead  = act && known_q && !flag_q;
        trail = inact && flag_q;
        width = (pcnt_q == '1) ? pcnt_q : pcnt_q + TW'(1);
        fire  = 1'b0;
        case (mode_q)
            3'd0, 3'd1: fire = lead;
            3'd2, 3'd4: fire = trail && (width < tthr_q);
            3'd3, 3'd5: fire = trail && (width >= tthr_q);
            3'd6:       fire = 1'b1;
            default:    fire = 1'b0;
        endcase
`ifdef TRIG_AUTO_EN
        auto_hit = (acnt_q == '1);
`else
        auto_hit = 1'b0;
`endif
    end

    // Next-state, configuration latch, level tracking and pulse width.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        vthr_d  = vthr_q;
        hyst_d  = hyst_q;
        tthr_d  = tthr_q;
        flag_d  = flag_q;
        known_d = known_q;
        pcnt_d  = pcnt_q;
        auto_d  = auto_q;
`ifdef TRIG_AUTO_EN
        acnt_d  = acnt_q;
`endif
        case (state_q)
            WAIT_PRE: begin
                if (Force) begin
                    state_d = FIRED;
                end else if (Sampled) begin
                    state_d = HUNT;
                    mode_d  = Mode;
                    vthr_d  = Vthr;
                    hyst_d  = Hyst;
                    tthr_d  = Tthr;
                    flag_d  = 1'b0;
                    known_d = 1'b0;
                    pcnt_d  = '0;
`ifdef TRIG_AUTO_EN
                    acnt_d  = '0;
`endif
                end
            end
            HUNT: begin
                if (inact) begin
                    flag_d  = 1'b0;
                    known_d = 1'b1;
                end else if (act && known_q) begin
                    flag_d  = 1'b1;
                end
                if (lead) begin
                    pcnt_d = '0;
                end else if (flag_q && !inact) begin
                    pcnt_d = width;
                end
`ifdef TRIG_AUTO_EN
                acnt_d = acnt_q + AUTO_W'(1);
`endif
                if (Force || fire) begin
                    state_d = FIRED;
                end else if (auto_hit) begin
                    state_d = FIRED;
                    auto_d  = 1'b1;
                end
            end
            FIRED: begin
                state_d = FIRED;
            end
            default: begin
                state_d = WAIT_PRE;
            end
        endcase
        armed_d = (state_d == HUNT);
        start_d = (state_d == FIRED);
    end

    // State and datapath registers, cleared asynchronously by ClrW.
    always_ff @(posedge Wclk or posedge ClrW) begin
        if (ClrW) begin
            state_q <= WAIT_PRE;
            mode_q  <= '0;
            vthr_q  <= '0;
            hyst_q  <= '0;
            tthr_q  <= '0;
            flag_q  <= 1'b0;
            known_q <= 1'b0;
            pcnt_q  <= '0;
            armed_q <= 1'b0;
            start_q <= 1'b0;
            auto_q  <= 1'b0;
`ifdef TRIG_AUTO_EN
            acnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            vthr_q  <= vthr_d;
            hyst_q  <= hyst_d;
            tthr_q  <= tthr_d;
            flag_q  <= flag_d;
            known_q <= known_d;
            pcnt_q  <= pcnt_d;
            armed_q <= armed_d;
            start_q <= start_d;
            auto_q  <= auto_d;
`ifdef TRIG_AUTO_EN
            acnt_q  <= acnt_d;
`endif
        end
    end

    assign Start = start_q;
    assign Armed = armed_q;
    assign Auto  = auto_q;

endmodule

// File: tb/tb_trig_start_gen.sv
// tb_trig_start_gen: directed scenarios plus randomized runs checked
// against a history-scanning reference model of the trigger rules.
module tb_trig_start_gen;

    logic        ClrW, Wclk, Sampled, Force;
    logic [7:0]  Din, Vthr, Hyst;
    logic [2:0]  Mode;
    logic [15:0] Tthr;
    logic        Start, Armed, Auto;

    int total = 0;
    int bad   = 0;

`ifdef TRIG_AUTO_EN
    trig_start_gen #(.DW(8), .TW(16), .AUTO_W(4)) dut (
        .ClrW(ClrW), .Wclk(Wclk), .Sampled(Sampled), .Din(Din),
        .Mode(Mode), .Vthr(Vthr), .Hyst(Hyst), .Tthr(Tthr),
        .Force(Force), .Start(Start), .Armed(Armed), .Auto(Auto));
`else
    trig_start_gen #(.DW(8), .TW(16)) dut (
        .ClrW(ClrW), .Wclk(Wclk), .Sampled(Sampled), .Din(Din),
        .Mode(Mode), .Vthr(Vthr), .Hyst(Hyst), .Tthr(Tthr),
        .Force(Force), .Start(Start), .Armed(Armed), .Auto(Auto));
`endif

    initial Wclk = 1'b0;
    always #5 Wclk = ~Wclk;

    // Reference model: outcome state plus the HUNT sample history.
    int ms;
    bit ma;
    int cm, cv, ch, ct;
    int hist[$];

    function automatic bit m_fire();
        int lo, hi, lvl, len, wid, n, s;
        bit ng, a, ia, ev_lead, ev_trail;
        n = hist.size();
        if (cm == 6) return (n == 1);
        if (cm == 7) return 1'b0;
        lo  = (cv - ch < 0) ? 0 : cv - ch;
        hi  = (cv + ch > 255) ? 255 : cv + ch;
        ng  = (cm == 1) || (cm == 4) || (cm == 5);
        lvl = -1;
        len = 0;
        wid = 0;
        ev_lead  = 0;
        ev_trail = 0;
        for (int i = 0; i < n; i++) begin
            s  = hist[i];
            ia = ng ? (s > hi) : (s < lo);
            a  = ng ? (s <= cv) : (s >= cv);
            ev_lead  = 0;
            ev_trail = 0;
            if (ia) begin
                if (lvl == 1) begin
                    ev_trail = 1;
                    wid = len;
                end
                lvl = 0;
            end else if (lvl == 1) begin
                if (len < 65535) len = len + 1;
            end else if (a && lvl == 0) begin
                ev_lead = 1;
                lvl = 1;
                len = 1;
            end
        end
        if (cm == 0 || cm == 1) return ev_lead;
        if (cm == 2 || cm == 4) return ev_trail && (wid < ct);
        return ev_trail && (wid >= ct);
    endfunction

    task automatic step(input logic [7:0] d);
        Din = d;
        @(posedge Wclk);
        #1;
    endtask

    task automatic pulse_clr();
        ClrW = 1'b1;
        #2;
        ClrW = 1'b0;
    endtask

    task automatic set_cfg(input logic [2:0] m, input logic [7:0] v,
                           input logic [7:0] h, input logic [15:0] t);
        Mode = m;
        Vthr = v;
        Hyst = h;
        Tthr = t;
    endtask

    task automatic test_reset();
        ClrW = 1'b1;
        Sampled = 1'b1;
        Force = 1'b0;
        set_cfg(3'd6, 8'h80, 8'h04, 16'd10);
        Din = 8'h90;
        repeat (2) @(posedge Wclk);
        #1;
        total++;
        if (Start !== 1'b0) begin
            bad++;
            $display("FAIL reset_start got=%b exp=0", Start);
        end
        total++;
        if (Armed !== 1'b0) begin
            bad++;
            $display("FAIL reset_armed got=%b exp=0", Armed);
        end
        total++;
        if (Auto !== 1'b0) begin
            bad++;
            $display("FAIL reset_auto got=%b exp=0", Auto);
        end
        ClrW = 1'b0;
        step(8'h90);
        total++;
        if (Armed !== 1'b1 || Start !== 1'b0) begin
            bad++;
            $display("FAIL reset_entry got=%b%b exp=10", Armed, Start);
        end
    endtask

    task automatic test_rising();
        pulse_clr();
        Sampled = 1'b1;
        set_cfg(3'd0, 8'h80, 8'h04, 16'd10);
        step(8'h40);
        step(8'h70);
        total++;
        if (Start !== 1'b0) begin
            bad++;
            $display("FAIL rise_low got=%b exp=0", Start);
        end
        step(8'h80);
        total++;
        if (Start !== 1'b1 || Armed !== 1'b0 || Auto !== 1'b0) begin
            bad++;
            $display("FAIL rise_fire got=%b%b%b exp=100", Start, Armed, Auto);
        end
        pulse_clr();
        step(8'h40);
        step(8'h7E);
        step(8'h80);
        step(8'h80);
        total++;
        if (Start !== 1'b0) begin
            bad++;
            $display("FAIL rise_hyst got=%b exp=0", Start);
        end
    endtask

    task automatic test_arming();
        pulse_clr();
        Sampled = 1'b0;
        set_cfg(3'd0, 8'h80, 8'h04, 16'd10);
        step(8'h70);
        step(8'h90);
        total++;
        if (Start !== 1'b0 || Armed !== 1'b0) begin
            bad++;
            $display("FAIL arm_idle got=%b%b exp=00", Start, Armed);
        end
        Sampled = 1'b1;
        step(8'h70);
        total++;
        if (Armed !== 1'b1) begin
            bad++;
            $display("FAIL arm_entry got=%b exp=1", Armed);
        end
        Sampled = 1'b0;
        step(8'h70);
        step(8'h90);
        total++;
        if (Start !== 1'b1 || Armed !== 1'b0) begin
            bad++;
            $display("FAIL arm_fire got=%b%b exp=10", Start, Armed);
        end
    endtask

    task automatic run_pulse(input logic [2:0] m, input int n,
                             input logic exp, input string nm);
        pulse_clr();
        Sampled = 1'b1;
        set_cfg(m, 8'h80, 8'h04, 16'd10);
        step(8'h10);
        step(8'h10);
        for (int i = 0; i < n; i++) step(8'h90);
        total++;
        if (Start !== 1'b0) begin
            bad++;
            $display("FAIL %s_early got=%b exp=0", nm, Start);
        end
        step(8'h10);
        total++;
        if (Start !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", nm, Start, exp);
        end
    endtask

    task automatic test_pulse();
        run_pulse(3'd2, 5, 1'b1, "pw_lt_5");
        run_pulse(3'd2, 10, 1'b0, "pw_lt_10");
        run_pulse(3'd2, 9, 1'b1, "pw_lt_9");
        run_pulse(3'd3, 10, 1'b1, "pw_ge_10");
        run_pulse(3'd3, 9, 1'b0, "pw_ge_9");
    endtask

    task automatic test_force();
        pulse_clr();
        Sampled = 1'b1;
        set_cfg(3'd7, 8'h80, 8'h04, 16'd10);
        step(8'h10);
        Mode = 3'd6;
        step(8'h10);
        step(8'h90);
        total++;
        if (Start !== 1'b0) begin
            bad++;
            $display("FAIL force_latch got=%b exp=0", Start);
        end
        Force = 1'b1;
        step(8'h90);
        Force = 1'b0;
        total++;
        if (Start !== 1'b1 || Auto !== 1'b0) begin
            bad++;
            $display("FAIL force_hunt got=%b%b exp=10", Start, Auto);
        end
        pulse_clr();
        Sampled = 1'b0;
        Force = 1'b1;
        step(8'h10);
        Force = 1'b0;
        total++;
        if (Start !== 1'b1 || Armed !== 1'b0) begin
            bad++;
            $display("FAIL force_wait got=%b%b exp=10", Start, Armed);
        end
    endtask

    task automatic test_clear();
        pulse_clr();
        Sampled = 1'b1;
        set_cfg(3'd6, 8'h80, 8'h04, 16'd10);
        step(8'h10);
        total++;
        if (Start !== 1'b0 || Armed !== 1'b1) begin
            bad++;
            $display("FAIL imm_entry got=%b%b exp=01", Start, Armed);
        end
        step(8'h10);
        total++;
        if (Start !== 1'b1) begin
            bad++;
            $display("FAIL imm_fire got=%b exp=1", Start);
        end
        ClrW = 1'b1;
        #1;
        total++;
        if (Start !== 1'b0 || Armed !== 1'b0) begin
            bad++;
            $display("FAIL clr_async got=%b%b exp=00", Start, Armed);
        end
        #1;
        ClrW = 1'b0;
        Sampled = 1'b0;
        step(8'h10);
        total++;
        if (Start !== 1'b0 || Armed !== 1'b0) begin
            bad++;
            $display("FAIL clr_wait got=%b%b exp=00", Start, Armed);
        end
        Sampled = 1'b1;
        step(8'h10);
        step(8'h10);
        total++;
        if (Start !== 1'b1) begin
            bad++;
            $display("FAIL clr_rearm got=%b exp=1", Start);
        end
    endtask

    task automatic test_auto();
        pulse_clr();
        Sampled = 1'b1;
        set_cfg(3'd7, 8'h80, 8'h04, 16'd10);
        step(8'h55);
`ifdef TRIG_AUTO_EN
        repeat (15) step(8'h55);
        total++;
        if (Start !== 1'b0 || Armed !== 1'b1) begin
            bad++;
            $display("FAIL auto_early got=%b%b exp=01", Start, Armed);
        end
        step(8'h55);
        total++;
        if (Start !== 1'b1 || Auto !== 1'b1) begin
            bad++;
            $display("FAIL auto_fire got=%b%b exp=11", Start, Auto);
        end
`else
        repeat (40) step(8'h55);
        total++;
        if (Start !== 1'b0 || Auto !== 1'b0 || Armed !== 1'b1) begin
            bad++;
            $display("FAIL auto_none got=%b%b%b exp=001", Start, Auto, Armed);
        end
`endif
    endtask

    task automatic test_random();
        int bm, bv, bh, bt, reg_sel, r, d;
        bit frc, smp, f;
        for (int run = 0; run < 60; run++) begin
            pulse_clr();
            ms = 0;
            ma = 0;
            hist.delete();
            bm = $urandom_range(0, 7);
            bv = $urandom_range(20, 235);
            bh = $urandom_range(0, 12);
            bt = $urandom_range(1, 8);
            reg_sel = $urandom_range(0, 3);
            for (int c = 0; c < 30; c++) begin
                frc = ($urandom_range(0, 49) == 0);
                if (ms == 0) begin
                    smp = ($urandom_range(0, 3) == 0);
                    set_cfg(3'(bm), 8'(bv), 8'(bh), 16'(bt));
                end else begin
                    smp = 1'($urandom);
                    set_cfg(3'($urandom), 8'($urandom), 8'($urandom),
                            16'($urandom_range(0, 15)));
                end
                if ($urandom_range(0, 4) == 0) reg_sel = $urandom_range(0, 3);
                r = $urandom_range(0, 3);
                case (reg_sel)
                    0: d = bv - bh - 1 - r;
                    1: d = bv + r;
                    2: d = bv - r;
                    default: d = bv + bh + 1 + r;
                endcase
                if ($urandom_range(0, 4) == 0) d = $urandom_range(0, 255);
                if (d < 0) d = 0;
                if (d > 255) d = 255;
                Sampled = smp;
                Force = frc;
                if (ms == 0) begin
                    if (frc) ms = 2;
                    else if (smp) begin
                        ms = 1;
                        cm = bm;
                        cv = bv;
                        ch = bh;
                        ct = bt;
                        hist.delete();
                    end
                end else if (ms == 1) begin
                    hist.push_back(d);
                    f = m_fire();
                    if (frc || f) ms = 2;
`ifdef TRIG_AUTO_EN
                    else if (hist.size() == 16) begin
                        ms = 2;
                        ma = 1;
                    end
`endif
                end
                step(8'(d));
                total++;
                if (Start !== (ms == 2)) begin
                    bad++;
                    $display("FAIL rnd_start run=%0d cyc=%0d got=%b exp=%b",
                             run, c, Start, ms == 2);
                end
                total++;
                if (Armed !== (ms == 1)) begin
                    bad++;
                    $display("FAIL rnd_armed run=%0d cyc=%0d got=%b exp=%b",
                             run, c, Armed, ms == 1);
                end
                total++;
                if (Auto !== ma) begin
                    bad++;
                    $display("FAIL rnd_auto run=%0d cyc=%0d got=%b exp=%b",
                             run, c, Auto, ma);
                end
            end
            Force = 1'b0;
        end
    endtask

    initial begin
        ClrW = 1'b1;
        Sampled = 1'b0;
        Force = 1'b0;
        Din = 8'h00;
        set_cfg(3'd0, 8'h80, 8'h04, 16'd10);
        test_reset();
        test_rising();
        test_arming();
        test_pulse();
        test_force();
        test_clear();
        test_auto();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
